ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer placed between the PC/branch logic and the byte-addressable instruction memory.
- Owns the fetch PC and issues one word request at a time to the memory.
- Buffers returned words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirects, including flushing stale prefetched and in-flight words.

---
 rtl/ifetch_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, issues one word request at a time to instruction memory,
// buffers returned words in a small prefetch FIFO and hands them to decode
// over a valid/ready handshake. Branch redirects flush the FIFO and drop any
// word still in flight.
// Optional feature macro: IFETCH_ALIGN_CHK_EN (alignment / range fault check).
module ifetch_ctrl #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2,
   parameter int                MEM_BYTES  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_code,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              fetch_fault
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // Elaboration-time parameter sanity.
   generate
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("ifetch_ctrl: FIFO_DEPTH must be a power of two >= 2");
      end
      if (MEM_BYTES < 4) begin : g_bad_mem
         $error("ifetch_ctrl: MEM_BYTES must hold at least one word");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [31:0]       fifo_word_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] wr_en;

   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] pc_inc;
   logic [CNT_W-1:0]  count_after;
   logic              next_ok;

`ifdef IFETCH_ALIGN_CHK_EN
   logic fault_q, fault_d;

   // A fetch is illegal if misaligned or if any byte of the word lies past
   // the end of memory; the extra bit keeps pc+3 from wrapping.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] last_byte;
      last_byte = {1'b0, a} + (ADDR_W+1)'(3);
      return (a[1:0] != 2'b00) || (last_byte >= (ADDR_W+1)'(MEM_BYTES));
   endfunction

   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   assign inst_valid  = (count_q != '0);
   assign pop         = inst_valid & inst_ready;
   assign inst_code   = inst_valid ? fifo_word_q[rd_ptr_q] : 32'h0;
   assign inst_pc     = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
   assign mem_req     = (state_q != ST_IDLE);
   // While discarding, the memory still sees the address of the stale request.
   assign mem_addr    = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
   assign pc_inc      = pc_q + ADDR_W'(4);
   // Occupancy after this cycle's push and pop; only meaningful when pushing.
   assign count_after = count_q + CNT_W'(1) - {{(CNT_W-1){1'b0}}, pop};

`ifdef IFETCH_ALIGN_CHK_EN
   // Back-to-back issue only continues to an address that passes the check;
   // otherwise IDLE re-evaluates and raises the fault.
   assign next_ok = !addr_bad(pc_inc);
`else
   assign next_ok = 1'b1;
`endif

   // Fetch sequencer: next state, next PC and push decision.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      disc_addr_d = disc_addr_q;
      push        = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
      fault_d     = fault_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (branch_valid) begin
               pc_d = branch_target;
            end else if (fetch_en && (count_q < DEPTH_C)) begin
`ifdef IFETCH_ALIGN_CHK_EN
               if (!fault_q) begin
                  if (addr_bad(pc_q)) begin
                     fault_d = 1'b1;
                  end else begin
                     state_d = ST_REQ;
                  end
               end
`else
               state_d = ST_REQ;
`endif
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               if (branch_valid) begin
                  state_d = ST_IDLE;
                  pc_d    = branch_target;
               end else begin
                  push = 1'b1;
                  pc_d = pc_inc;
                  if (fetch_en && (count_after < DEPTH_C) && next_ok) begin
                     state_d = ST_REQ;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end else if (branch_valid) begin
               state_d     = ST_DISCARD;
               disc_addr_d = pc_q;
               pc_d        = branch_target;
            end
         end
         ST_DISCARD: begin
            if (branch_valid) begin
               pc_d = branch_target;
            end
            if (mem_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO pointer/occupancy update; a branch empties the buffer outright.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (branch_valid) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
      end
   endgenerate

   // Sequencer and FIFO control registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         disc_addr_q <= RESET_PC;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         disc_addr_q <= disc_addr_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
      end
   end

   // FIFO storage: each entry holds {pc, word} of one returned fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_word_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en[i]) begin
               fifo_pc_q[i]   <= pc_q;
               fifo_word_q[i] <= mem_rdata;
            end
         end
      end
   end

`ifdef IFETCH_ALIGN_CHK_EN
   // Sticky fault flag; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end
`endif

`ifndef SYNTHESIS
   // The issue-time room check must make a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && (count_q == DEPTH_C)));
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl with a transaction-level reference model:
// a queue of delivered-able {pc, word} entries, the expected next fetch
// address, and a stale flag for a request overtaken by a branch.
module tb_ifetch_ctrl;

   localparam int FIFO_DEPTH   = 2;
   localparam int MEM_BYTES_TB = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_code;
   logic [31:0] inst_pc;
   logic        fetch_fault;

   ifetch_ctrl #(
      .ADDR_W     (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (FIFO_DEPTH),
      .MEM_BYTES  (MEM_BYTES_TB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_code     (inst_code),
      .inst_pc       (inst_pc),
      .fetch_fault   (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   ent_t        sb[$];
   logic        outstanding;
   logic        stale;
   logic [31:0] out_addr;
   logic [31:0] fetch_pc;
   logic        prev_fetch_en;
   logic        prev_branch;
   int          lat_cnt;
   int          lat_min;
   int          lat_max;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0)  return 32'h0094_0333;
      if (a == 32'h10) return 32'h0019_ceb3;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      sb.delete();
      outstanding   = 1'b0;
      stale         = 1'b0;
      out_addr      = 32'h0;
      fetch_pc      = 32'h0;
      prev_fetch_en = 1'b0;
      prev_branch   = 1'b0;
      lat_cnt       = 0;
   endtask

   // One clock: memory response and model update for the coming edge, then
   // post-edge checks of the visible state against the model.
   task automatic cycle();
      logic ack;
      ent_t e;
      mem_ack = 1'b0;
      if (outstanding) begin
         check_val("addr_hold", mem_addr, out_addr);
         if (lat_cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(out_addr);
         end else begin
            lat_cnt--;
            mem_rdata = $urandom;
         end
      end else begin
         mem_rdata = $urandom;
      end
      #1;
      ack = mem_ack;
      if (inst_valid && inst_ready) begin
         $display("pop pc=%08h code=%08h", inst_pc, inst_code);
         if (sb.size() == 0) begin
            check_val("pop_empty", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check_val("inst_pc", inst_pc, e.pc);
            check_val("inst_code", inst_code, e.word);
         end
      end
      if (branch_valid) begin
         sb.delete();
         fetch_pc = branch_target;
         if (outstanding) begin
            if (ack) begin
               outstanding = 1'b0;
               stale       = 1'b0;
            end else begin
               stale = 1'b1;
            end
         end
      end else if (ack) begin
         if (!stale) begin
            e.pc   = out_addr;
            e.word = mem_rdata;
            sb.push_back(e);
            fetch_pc = out_addr + 32'd4;
         end
         outstanding = 1'b0;
         stale       = 1'b0;
      end
      prev_fetch_en = fetch_en;
      prev_branch   = branch_valid;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      check_val("inst_valid", inst_valid, sb.size() != 0);
      check_val("occupancy", sb.size() <= FIFO_DEPTH, 1);
      if (outstanding) begin
         check_val("req_hold", mem_req, 1);
      end else if (mem_req) begin
         check_val("issue_en", prev_fetch_en && !prev_branch, 1);
         check_val("issue_room", sb.size() < FIFO_DEPTH, 1);
         check_val("issue_addr", mem_addr, fetch_pc);
         outstanding = 1'b1;
         stale       = 1'b0;
         out_addr    = mem_addr;
         lat_cnt     = $urandom_range(lat_max, lat_min);
      end
   endtask

   // Run cycles until a condition holds (0: inst_valid, 1: mem_req,
   // 2: request and FIFO both idle); an exhausted budget is a failure.
   task automatic wait_for(input int sel, input int bound, input string tag);
      int  n;
      bit  hit;
      n   = 0;
      hit = 0;
      while (!hit && n < bound) begin
         case (sel)
            0:       hit = inst_valid;
            1:       hit = mem_req;
            default: hit = !mem_req && !inst_valid;
         endcase
         if (!hit) begin
            cycle();
            n++;
         end
      end
      if (!hit) check_val(tag, 64'd0, 64'd1);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      reset         = 1'b0;
      fetch_en      = 1'b0;
      branch_valid  = 1'b0;
      branch_target = 32'h0;
      inst_ready    = 1'b0;
      mem_ack       = 1'b0;
      mem_rdata     = 32'h0;
      #1;
      if (chk) begin
         check_val("rst_mem_req", mem_req, 0);
         check_val("rst_mem_addr", mem_addr, 32'h0);
         check_val("rst_inst_valid", inst_valid, 0);
         check_val("rst_inst_code", inst_code, 32'h0);
         check_val("rst_inst_pc", inst_pc, 32'h0);
         check_val("rst_fault", fetch_fault, 0);
      end
      @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] old_addr;
      reset         = 1'b0;
      fetch_en      = 1'b0;
      branch_valid  = 1'b0;
      branch_target = 32'h0;
      inst_ready    = 1'b0;
      mem_ack       = 1'b0;
      mem_rdata     = 32'h0;
      lat_min       = 0;
      lat_max       = 0;
      model_reset();

      // Reset values, then zero-wait streaming: latency and throughput.
      do_reset(1);
      fetch_en   = 1'b1;
      inst_ready = 1'b1;
      cycle();
      check_val("lat_req", mem_req, 1);
      check_val("lat_not_valid", inst_valid, 0);
      cycle();
      check_val("lat_valid", inst_valid, 1);
      check_val("first_pc", inst_pc, 32'h0);
      check_val("first_code", inst_code, 32'h0094_0333);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         check_val("thru_valid", inst_valid, 1);
         check_val("thru_pc", inst_pc, 32'(k * 4));
      end

      // Backpressure: FIFO fills to depth and requests stop.
      inst_ready = 1'b0;
      repeat (6) cycle();
      check_val("bp_noreq", mem_req, 0);
      check_val("bp_valid", inst_valid, 1);
      check_val("bp_count", sb.size(), FIFO_DEPTH);
      inst_ready = 1'b1;
      repeat (10) cycle();

      // Slow memory, branch during the second wait cycle: word discarded.
      fetch_en = 1'b0;
      wait_for(2, 20, "drain_timeout");
      lat_min  = 3;
      lat_max  = 3;
      fetch_en = 1'b1;
      wait_for(1, 10, "req_timeout");
      old_addr = mem_addr;
      cycle();
      branch_valid  = 1'b1;
      branch_target = 32'h10;
      cycle();
      branch_valid  = 1'b0;
      check_val("disc_req", mem_req, 1);
      check_val("disc_addr", mem_addr, old_addr);
      check_val("disc_valid", inst_valid, 0);
      wait_for(0, 30, "disc_timeout");
      check_val("br_pc", inst_pc, 32'h10);
      check_val("br_code", inst_code, 32'h0019_ceb3);

      // Branch coinciding with ack and pop in a zero-wait stream.
      lat_min = 0;
      lat_max = 0;
      repeat (6) cycle();
      check_val("bap_pre", mem_req && mem_ack == 1'b0 && inst_valid, 1);
      branch_valid  = 1'b1;
      branch_target = 32'h40;
      cycle();
      branch_valid  = 1'b0;
      check_val("bap_flush", inst_valid, 0);
      check_val("bap_idle", mem_req, 0);
      wait_for(0, 10, "bap_timeout");
      check_val("bap_pc", inst_pc, 32'h40);

`ifndef IFETCH_ALIGN_CHK_EN
      // PC wrap at the top of the address space.
      branch_valid  = 1'b1;
      branch_target = 32'hFFFF_FFFC;
      cycle();
      branch_valid  = 1'b0;
      wait_for(0, 10, "wrap_timeout");
      check_val("wrap_top", inst_pc, 32'hFFFF_FFFC);
      cycle();
      check_val("wrap_zero", inst_pc, 32'h0);
`endif

      // Asynchronous reset mid-request, then a late ack that must be ignored.
      fetch_en = 1'b0;
      wait_for(2, 20, "drain2_timeout");
      lat_min  = 3;
      lat_max  = 3;
      fetch_en = 1'b1;
      wait_for(1, 10, "req2_timeout");
      #2;
      reset = 1'b0;
      #1;
      check_val("arst_req", mem_req, 0);
      check_val("arst_addr", mem_addr, 32'h0);
      check_val("arst_valid", inst_valid, 0);
      @(negedge clk);
      reset     = 1'b1;
      fetch_en  = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_ack = 1'b0;
      check_val("late_ack_valid", inst_valid, 0);
      check_val("late_ack_req", mem_req, 0);
      model_reset();

`ifdef IFETCH_ALIGN_CHK_EN
      // Misaligned branch target raises a sticky fault; reset clears it.
      branch_valid  = 1'b1;
      branch_target = 32'h1E;
      cycle();
      branch_valid  = 1'b0;
      fetch_en      = 1'b1;
      repeat (3) cycle();
      check_val("fault_set", fetch_fault, 1);
      check_val("fault_noreq", mem_req, 0);
      do_reset(1);
      fetch_en   = 1'b1;
      inst_ready = 1'b1;
      lat_min    = 0;
      lat_max    = 0;
      wait_for(0, 10, "fault_resume_timeout");
      check_val("fault_resume_pc", inst_pc, 32'h0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ((i % 250) == 0) begin
            lat_min = 0;
            lat_max = ($urandom_range(0, 2) == 0) ? 0 : 3;
         end
         fetch_en      = ($urandom_range(0, 7) != 0);
         inst_ready    = ($urandom_range(0, 3) != 0);
         branch_valid  = ($urandom_range(0, 19) == 0);
         branch_target = 32'($urandom_range(0, 63)) << 2;
         cycle();
      end

      // Drain.
      branch_valid = 1'b0;
      fetch_en     = 1'b0;
      inst_ready   = 1'b1;
      repeat (20) cycle();
      check_val("drain_end", inst_valid, 0);
`ifndef IFETCH_ALIGN_CHK_EN
      check_val("fault_tied", fetch_fault, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
